sdram_init_refresh: RTL and testbench
=====================================

SDRAM_INIT_REFRESH -- requirements
Module: sdram_init_refresh

Interface
REQ-001 SHALL have parameter PWRUP_CYC, default 5000: power-up NOP wait in HCLK cycles (100 us at 20 ns).
REQ-002 SHALL have parameter REF_INTERVAL, default 750: HCLK cycles between refresh requests.
REQ-003 SHALL have parameter TRP_CYC, default 1: idle cycles after PRECHARGE.
REQ-004 SHALL have parameter TRFC_CYC, default 3: idle cycles after AUTO REFRESH.
REQ-005 SHALL have parameter TMRD_CYC, default 2: idle cycles after LOAD MODE.
REQ-006 SHALL have parameter MODE_REG, default 12'h010: mode word (CL=1, burst length 1, sequential).
REQ-007 SHALL have port HCLK, input, 1: sole clock, rising-edge.
REQ-008 SHALL have port HRESETn, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port txn_active, input, 1: controller read/write sequence in progress.
REQ-010 SHALL have port cmd_own, output, 1: this block drives the SDRAM command bus this cycle.
REQ-011 SHALL have port cmd, output, 4: {CSn,RASn,CASn,WEn}.
REQ-012 SHALL have port addr, output, 12: MEM_ADDR value when cmd_own=1.
REQ-013 SHALL have port ba, output, 2: MEM_BA value, always 2'b00.
REQ-014 SHALL have port cke, output, 1: MEM_CKE.
REQ-015 SHALL have port init_done, output, 1: init sequence complete, sticky until reset.
REQ-016 SHALL have port hold, output, 1: controller must not start a new AHB transaction (HREADYOUT low).
REQ-017 SHALL have port ref_missed, output, 1: sticky; a second interval elapsed while a refresh was still pending.

Function
REQ-018 Command encodings SHALL be NOP=0111, PRECHARGE=0010, AUTO_REFRESH=0001, LOAD_MODE=0000.
REQ-019 Outside the cycles of REQ-020 to REQ-023, cmd SHALL be NOP and addr SHALL be 0.
REQ-020 In each PRECHARGE cycle, addr[10] SHALL be 1 (all banks).
REQ-021 In each LOAD_MODE cycle, addr SHALL be MODE_REG.
REQ-022 FSM states SHALL be PWRUP, I_PRE, I_PRE_W, I_REF1, I_REF1_W, I_REF2, I_REF2_W, I_LMR, I_LMR_W, IDLE, R_HOLD, R_PRE, R_PRE_W, R_REF, R_REF_W.
REQ-023 Each command state (I_PRE, I_REF1, I_REF2, I_LMR, R_PRE, R_REF) SHALL last exactly 1 cycle.
REQ-024 Each _W state SHALL last exactly its T*_CYC cycles, using one shared down-counter.
REQ-025 PWRUP SHALL last PWRUP_CYC cycles with cke=1.
REQ-026 After PWRUP, states SHALL run I_PRE to I_LMR_W in fixed order, then IDLE.
REQ-027 On IDLE entry from I_LMR_W, init_done SHALL set to 1.
REQ-028 cmd_own SHALL be 1 in every state except IDLE and R_HOLD.
REQ-029 hold SHALL be 1 in all states before init_done and whenever ref_pending=1.
REQ-030 The refresh counter SHALL start at 0 on IDLE entry and count every cycle afterwards regardless of state.
REQ-031 At count REF_INTERVAL-1, the counter SHALL set ref_pending and wrap to 0.
REQ-032 IDLE with ref_pending SHALL go to R_HOLD.
REQ-033 R_HOLD SHALL wait until txn_active=0, then go to R_PRE on the next cycle.
REQ-034 The refresh sequence SHALL run R_PRE, R_PRE_W, R_REF, R_REF_W, IDLE.
REQ-035 ref_pending SHALL clear on the R_REF cycle.
REQ-036 If the counter wrap coincides with the R_REF cycle, ref_pending SHALL remain 1 (the new request wins).
REQ-037 If the counter wraps while ref_pending=1 (other than on R_REF), ref_missed SHALL set.
REQ-038 txn_active SHALL be ignored outside R_HOLD.

Reset
REQ-039 While HRESETn=0, outputs SHALL be: state PWRUP, cmd=0111, addr=0, ba=0, cke=0, cmd_own=1, init_done=0, hold=1, ref_missed=0.
REQ-040 While HRESETn=0, internal state SHALL be: ref_pending=0, all counters 0.
REQ-041 Deassertion SHALL begin PWRUP counting on the first rising edge, with cke=1 from that edge.
REQ-042 Reset asserted in any state, including mid-refresh, SHALL abort immediately and restart full init.

Structure
REQ-043 Package sdram_pkg SHALL hold the command encoding constants, the state enum type, and the MODE_REG default.
REQ-044 The refresh interval counter SHALL be sub-module ref_timer (ports: HCLK, HRESETn, enable, wrap pulse).
REQ-045 The FSM and shared wait counter SHALL reside in the top module.

Verification (PWRUP_CYC=8, REF_INTERVAL=750 unless noted)
REQ-046 Init: release reset -> 8 NOP cycles, then PRE(addr=0x400) at cycle 8, REF at 10, REF at 14, LMR(0x010) at 18, init_done=1 at cycle 21.
REQ-047 Periodic refresh: txn_active=0 -> PRE/REF pair every 750 cycles, hold high exactly 6 cycles each.
REQ-048 Deferred refresh: txn_active=1 held 20 cycles across the wrap -> hold=1, cmd_own=0 for those 20 cycles, PRE issued 1 cycle after txn_active falls.
REQ-049 Missed refresh: txn_active=1 for 800 cycles -> ref_missed=1 at the second wrap, exactly one refresh performed afterwards.
REQ-050 Reset mid-refresh: HRESETn low during R_PRE_W -> cmd=NOP, cke=0, init_done=0 immediately; full init repeats after release.
REQ-051 Coincidence (REF_INTERVAL=5, txn_active=0): wrap lands on R_REF -> ref_pending stays 1, next PRE follows the R_REF_W exit with no IDLE gap.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, FSM state type and defaults for the
// init/refresh sequencer.
package sdram_pkg;

    localparam logic [3:0]  CMD_NOP          = 4'b0111;
    localparam logic [3:0]  CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0]  CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0]  CMD_LOAD_MODE    = 4'b0000;

    localparam logic [11:0] MODE_REG_DEFAULT = 12'h010;
    localparam logic [11:0] ADDR_ALL_BANKS   = 12'h400;

    typedef enum logic [3:0] {
        PWRUP,
        I_PRE,
        I_PRE_W,
        I_REF1,
        I_REF1_W,
        I_REF2,
        I_REF2_W,
        I_LMR,
        I_LMR_W,
        IDLE,
        R_HOLD,
        R_PRE,
        R_PRE_W,
        R_REF,
        R_REF_W
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_init_refresh_ref_timer.sv
// Free-running refresh interval counter; emits a one-cycle wrap pulse every
// REF_INTERVAL enabled cycles.
module ref_timer #(
    parameter int REF_INTERVAL = 750
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic enable,
    output logic wrap
);

    localparam int CW = $clog2(REF_INTERVAL + 1);
    localparam logic [CW-1:0] LAST = CW'(REF_INTERVAL - 1);

    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up initialisation and periodic auto-refresh sequencer; owns the
// command bus during init and refresh, otherwise yields it to the controller.
module sdram_init_refresh
    import sdram_pkg::*;
#(
    parameter int          PWRUP_CYC    = 5000,
    parameter int          REF_INTERVAL = 750,
    parameter int          TRP_CYC      = 1,
    parameter int          TRFC_CYC     = 3,
    parameter int          TMRD_CYC     = 2,
    parameter logic [11:0] MODE_REG     = MODE_REG_DEFAULT
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        txn_active,
    output logic        cmd_own,
    output logic [3:0]  cmd,
    output logic [11:0] addr,
    output logic [1:0]  ba,
    output logic        cke,
    output logic        init_done,
    output logic        hold,
    output logic        ref_missed
);

    localparam int WAIT_MAX = max_int(PWRUP_CYC, max_int(TRP_CYC, max_int(TRFC_CYC, TMRD_CYC)));
    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] PWRUP_LAST = WW'(PWRUP_CYC);
    localparam logic [WW-1:0] TRP_LOAD   = WW'(TRP_CYC - 1);
    localparam logic [WW-1:0] TRFC_LOAD  = WW'(TRFC_CYC - 1);
    localparam logic [WW-1:0] TMRD_LOAD  = WW'(TMRD_CYC - 1);

    state_e        state_d, state_q;
    logic [WW-1:0] wait_d, wait_q;
    logic [3:0]    cmd_d, cmd_q;
    logic [11:0]   addr_d, addr_q;
    logic          cmd_own_d, cmd_own_q;
    logic          init_done_d, init_done_q;
    logic          hold_d, hold_q;
    logic          ref_pending_d, ref_pending_q;
    logic          ref_missed_d, ref_missed_q;
    logic          wait_done;
    logic          ref_wrap;

    ref_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref_timer (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .enable  (init_done_q),
        .wrap    (ref_wrap)
    );

    assign wait_done = (wait_q == '0);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            // Power-up counts up from the reset value; the _W states count down.
            PWRUP: begin
                if (wait_q == PWRUP_LAST) begin
                    state_d = I_PRE;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            I_PRE:    begin state_d = I_PRE_W;  wait_d = TRP_LOAD;  end
            I_PRE_W:  if (wait_done) state_d = I_REF1; else wait_d = wait_q - 1'b1;
            I_REF1:   begin state_d = I_REF1_W; wait_d = TRFC_LOAD; end
            I_REF1_W: if (wait_done) state_d = I_REF2; else wait_d = wait_q - 1'b1;
            I_REF2:   begin state_d = I_REF2_W; wait_d = TRFC_LOAD; end
            I_REF2_W: if (wait_done) state_d = I_LMR;  else wait_d = wait_q - 1'b1;
            I_LMR:    begin state_d = I_LMR_W;  wait_d = TMRD_LOAD; end
            I_LMR_W:  if (wait_done) state_d = IDLE;   else wait_d = wait_q - 1'b1;
            IDLE:     if (ref_pending_q) state_d = R_HOLD;
            R_HOLD:   if (!txn_active) state_d = R_PRE;
            R_PRE:    begin state_d = R_PRE_W;  wait_d = TRP_LOAD;  end
            R_PRE_W:  if (wait_done) state_d = R_REF;  else wait_d = wait_q - 1'b1;
            R_REF:    begin state_d = R_REF_W;  wait_d = TRFC_LOAD; end
            // A request that arrived during R_REF is served back-to-back; hold has
            // stayed high throughout, so no controller transaction can be in flight.
            R_REF_W: begin
                if (wait_done) state_d = ref_pending_q ? R_PRE : IDLE;
                else           wait_d  = wait_q - 1'b1;
            end
            default:  state_d = PWRUP;
        endcase

        cmd_d     = CMD_NOP;
        addr_d    = '0;
        cmd_own_d = 1'b1;
        case (state_d)
            I_PRE, R_PRE:         begin cmd_d = CMD_PRECHARGE; addr_d = ADDR_ALL_BANKS; end
            I_REF1, I_REF2, R_REF: cmd_d = CMD_AUTO_REFRESH;
            I_LMR:                begin cmd_d = CMD_LOAD_MODE; addr_d = MODE_REG; end
            IDLE, R_HOLD:          cmd_own_d = 1'b0;
            default:               ;
        endcase

        init_done_d   = init_done_q | ((state_q == I_LMR_W) && (state_d == IDLE));
        ref_pending_d = ref_wrap ? 1'b1 : ((state_q == R_REF) ? 1'b0 : ref_pending_q);
        ref_missed_d  = ref_missed_q | (ref_wrap && ref_pending_q && (state_q != R_REF));
        hold_d        = !init_done_d || ref_pending_d;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= PWRUP;
            wait_q        <= '0;
            cmd_q         <= CMD_NOP;
            addr_q        <= '0;
            cke           <= 1'b0;
            cmd_own_q     <= 1'b1;
            init_done_q   <= 1'b0;
            hold_q        <= 1'b1;
            ref_pending_q <= 1'b0;
            ref_missed_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            cke           <= 1'b1;
            cmd_own_q     <= cmd_own_d;
            init_done_q   <= init_done_d;
            hold_q        <= hold_d;
            ref_pending_q <= ref_pending_d;
            ref_missed_q  <= ref_missed_d;
        end
    end

    assign cmd        = cmd_q;
    assign addr       = addr_q;
    assign ba         = 2'b00;
    assign cmd_own    = cmd_own_q;
    assign init_done  = init_done_q;
    assign ref_missed = ref_missed_q;
    // Raise hold in the wrap cycle itself so no transaction starts as a refresh falls due.
    assign hold       = hold_q | ref_wrap;

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Scoreboard bench: expected SDRAM commands are queued ahead of time and a
// monitor pops them as commands appear on the bus.
module tb_sdram_init_refresh;
    import sdram_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic        txn_active;
    logic        cmd_own, cke, init_done, hold, ref_missed;
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic [1:0]  ba;

    logic        txn_active2;
    logic        cmd_own2, cke2, init_done2, hold2, ref_missed2;
    logic [3:0]  cmd2;
    logic [11:0] addr2;
    logic [1:0]  ba2;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = -1;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [11:0] addr;
    } exp_t;
    exp_t exp_q[$];

    sdram_init_refresh #(.PWRUP_CYC(8), .REF_INTERVAL(750)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .txn_active(txn_active),
        .cmd_own(cmd_own), .cmd(cmd), .addr(addr), .ba(ba), .cke(cke),
        .init_done(init_done), .hold(hold), .ref_missed(ref_missed)
    );

    sdram_init_refresh #(.PWRUP_CYC(8), .REF_INTERVAL(5)) dut5 (
        .HCLK(HCLK), .HRESETn(HRESETn), .txn_active(txn_active2),
        .cmd_own(cmd_own2), .cmd(cmd2), .addr(addr2), .ba(ba2), .cke(cke2),
        .init_done(init_done2), .hold(hold2), .ref_missed(ref_missed2)
    );

    initial HCLK = 1'b0;
    always #10 HCLK = ~HCLK;

    // Cycle k is the interval following the k-th rising edge after reset release.
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cyc <= -1;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, req, cyc);
    endtask

    task automatic push_exp(input int c, input logic [3:0] k, input logic [11:0] a);
        exp_t e;
        e.cyc  = c;
        e.cmd  = k;
        e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push_exp(8,  CMD_PRECHARGE,    12'h400);
        push_exp(10, CMD_AUTO_REFRESH, 12'h000);
        push_exp(14, CMD_AUTO_REFRESH, 12'h000);
        push_exp(18, CMD_LOAD_MODE,    12'h010);
    endtask

    task automatic wait_until(input int c);
        int guard = 0;
        while (cyc != c) begin
            @(negedge HCLK);
            guard++;
            if (guard > 20000) begin
                $display("FAIL wait_cycle: got cyc %0d required %0d", cyc, c);
                $fatal(1, "cycle wait expired");
            end
        end
    endtask

    task automatic count_hold(input int from, input int to, input int req, input string name);
        int n = 0;
        wait_until(from);
        while (cyc < to) begin
            if (hold) n++;
            @(negedge HCLK);
        end
        check(name, n, req);
    endtask

    always @(negedge HCLK) begin : sb_monitor
        exp_t e;
        if (HRESETn === 1'b1 && cmd !== CMD_NOP) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL cmd_seq: got cyc=%0d cmd=%b addr=%h, required no command", cyc, cmd, addr);
            end else begin
                e = exp_q.pop_front();
                if (cyc == e.cyc && cmd === e.cmd && addr === e.addr && cmd_own === 1'b1 && ba === 2'b00)
                    n_pass++;
                else
                    $display("FAIL cmd_seq: got cyc=%0d cmd=%b addr=%h own=%b, required cyc=%0d cmd=%b addr=%h own=1",
                             cyc, cmd, addr, cmd_own, e.cyc, e.cmd, e.addr);
            end
        end
    end

    initial begin : coincidence
        logic [3:0] e_cmd [0:11];
        logic       e_own [0:11];
        logic       e_mis [0:11];
        e_cmd = '{CMD_NOP, CMD_NOP, CMD_NOP, CMD_PRECHARGE, CMD_NOP, CMD_AUTO_REFRESH,
                  CMD_NOP, CMD_NOP, CMD_NOP, CMD_PRECHARGE, CMD_NOP, CMD_AUTO_REFRESH};
        e_own = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        e_mis = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        txn_active2 = 1'b0;
        wait_until(25);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("coinc_c%0d", 25 + i),
                  {24'd0, cmd2, cmd_own2, hold2, ref_missed2},
                  {24'd0, e_cmd[i], e_own[i], 1'b1, e_mis[i]});
            @(negedge HCLK);
        end
    end

    initial begin : stimulus
        int bad;
        HRESETn    = 1'b0;
        txn_active = 1'b0;
        repeat (3) @(negedge HCLK);

        check("rst_cmd", cmd, CMD_NOP);
        check("rst_addr", addr, 0);
        check("rst_ba", ba, 0);
        check("rst_cke", cke, 0);
        check("rst_cmd_own", cmd_own, 1);
        check("rst_init_done", init_done, 0);
        check("rst_hold", hold, 1);
        check("rst_ref_missed", ref_missed, 0);

        push_init();
        HRESETn = 1'b1;
        wait_until(0);
        check("pwrup_cke", cke, 1);
        check("pwrup_cmd", cmd, CMD_NOP);
        wait_until(20);
        check("init_done_c20", init_done, 0);
        check("hold_c20", hold, 1);
        wait_until(21);
        check("init_done_c21", init_done, 1);
        check("hold_c21", hold, 0);
        check("cmd_own_c21", cmd_own, 0);

        push_exp(773,  CMD_PRECHARGE,    12'h400);
        push_exp(775,  CMD_AUTO_REFRESH, 12'h000);
        push_exp(1523, CMD_PRECHARGE,    12'h400);
        push_exp(1525, CMD_AUTO_REFRESH, 12'h000);
        count_hold(760, 790, 6, "hold_len_1");
        count_hold(1510, 1540, 6, "hold_len_2");
        check("no_miss_periodic", ref_missed, 0);

        push_exp(2291, CMD_PRECHARGE,    12'h400);
        push_exp(2293, CMD_AUTO_REFRESH, 12'h000);
        wait_until(2270);
        bad = 0;
        txn_active = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (hold !== 1'b1 || cmd_own !== 1'b0) bad++;
            @(negedge HCLK);
        end
        txn_active = 1'b0;
        check("defer_hold_own", bad, 0);

        push_exp(3821, CMD_PRECHARGE,    12'h400);
        push_exp(3823, CMD_AUTO_REFRESH, 12'h000);
        push_exp(4523, CMD_PRECHARGE,    12'h400);
        wait_until(3020);
        txn_active = 1'b1;
        wait_until(3770);
        check("missed_before", ref_missed, 0);
        wait_until(3771);
        check("missed_set", ref_missed, 1);
        check("missed_hold", hold, 1);
        wait_until(3820);
        txn_active = 1'b0;
        wait_until(3830);
        check("missed_pending_clear", hold, 0);

        wait_until(4524);
        HRESETn = 1'b0;
        #1;
        check("abort_cmd", cmd, CMD_NOP);
        check("abort_cke", cke, 0);
        check("abort_init_done", init_done, 0);
        check("abort_cmd_own", cmd_own, 1);
        check("abort_hold", hold, 1);
        check("abort_ref_missed", ref_missed, 0);
        @(negedge HCLK);
        @(negedge HCLK);
        push_init();
        HRESETn = 1'b1;
        wait_until(21);
        check("reinit_done", init_done, 1);
        wait_until(40);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish by cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
